// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity modes, serializer
// state encodings and the default bit period.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // 100 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered occupancy. Full/empty are decoded from the
// level register so pointers can wrap freely modulo DEPTH. A read in the same
// cycle never frees a slot for a write in that cycle (full gates the write).
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; flushing is done through the pointers, so no reset here
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_gen.sv
// Parametrised UART transmitter with a word FIFO in front of the serializer.
// Frames are sent back to back when words are queued: the last stop-bit cycle
// moves straight into the next start bit. The line is driven from a register
// loaded with the value belonging to the next state.
module uart_tx_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_W       = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_W-1:0]                  tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               tx,
    output logic                               tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W+1);

    tx_state_t          state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [DATA_W-1:0]  shreg, shreg_n;
    logic               par_bit, par_n;
    logic               tx_n;
    logic               busy_n;
    logic               bit_end;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_rd_data;

    uart_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign tx_ready = !fifo_full;
    assign bit_end  = (cnt == CNT_W'(CLKS_PER_BIT-1));

    // Next-state, bit timing and shift-register control
    always_comb begin
        state_n = state;
        cnt_n   = bit_end ? '0 : cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par_bit;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!fifo_empty) begin
                    state_n = S_START;
                    pop     = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    idx_n   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx == IDX_W'(DATA_W-1)) begin
                        state_n = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        idx_n   = '0;
                    end else begin
                        idx_n   = idx + 1'b1;
                        shreg_n = shreg >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    idx_n   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (idx == IDX_W'(STOP_BITS-1)) begin
                        if (!fifo_empty) begin
                            state_n = S_START;
                            pop     = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Popping a word loads the shifter and fixes the parity for the frame
        if (pop) begin
            shreg_n = fifo_rd_data;
            par_n   = (^fifo_rd_data) ^ (PARITY == PAR_ODD);
            idx_n   = '0;
            cnt_n   = '0;
        end
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
            S_PARITY: tx_n = par_n;
            default:  tx_n = 1'b1;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // Serializer state and registered line outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            par_bit <= par_n;
            tx      <= tx_n;
            tx_busy <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Three transmitters in different frame formats driven with directed and
// random traffic; a cycle-level reference model checks the line and status
// outputs, and a serial receiver checks decoded words against a scoreboard.
module tb_uart_tx_gen;

    localparam int CPB = 16;
    localparam int ND  = 3;

    // dut0: 8N1 depth 4, dut1: 9O2 depth 4, dut2: 8E1 depth 2
    function automatic int cfg_dw(int g);  return (g == 1) ? 9 : 8; endfunction
    function automatic int cfg_par(int g); return (g == 0) ? 0 : ((g == 1) ? 2 : 1); endfunction
    function automatic int cfg_sb(int g);  return (g == 1) ? 2 : 1; endfunction
    function automatic int cfg_dp(int g);  return (g == 2) ? 2 : 4; endfunction
    function automatic int nbits(int g);
        return 1 + cfg_dw(g) + ((cfg_par(g) != 0) ? 1 : 0) + cfg_sb(g);
    endfunction

    // Expected line bits of a whole frame, index 0 = start bit
    function automatic logic [15:0] frame_of(int g, int w);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < cfg_dw(g); i++) f[1+i] = w[i];
        if (cfg_par(g) != 0)
            f[1+cfg_dw(g)] = (($countones(w) % 2) == 1) ^ (cfg_par(g) == 2);
        return f;
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic       vld [ND];
    logic [8:0] dat [ND];
    logic       rdy [ND];
    logic       txl [ND];
    logic       bsy [ND];
    logic [2:0] lvl [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int DW = cfg_dw(g);
        localparam int DP = cfg_dp(g);
        logic [$clog2(DP+1)-1:0] lv;
        uart_tx_gen #(
            .CLKS_PER_BIT (CPB),
            .DATA_W       (DW),
            .PARITY       (cfg_par(g)),
            .STOP_BITS    (cfg_sb(g)),
            .FIFO_DEPTH   (DP)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .tx_data    (dat[g][DW-1:0]),
            .tx_valid   (vld[g]),
            .tx_ready   (rdy[g]),
            .tx         (txl[g]),
            .tx_busy    (bsy[g]),
            .fifo_level (lv)
        );
        assign lvl[g] = 3'(lv);
    end

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic        stim_done;
    logic        stim_err;

    int          q_m [ND][$];
    int          sbq [ND][$];
    int          rem [ND];
    logic [15:0] fb  [ND];
    logic        rx_act [ND];
    int          rx_cnt [ND];
    logic [15:0] rx_b [ND];

    int          fl, ew, w;
    logic [31:0] rw;
    logic [15:0] ef;
    logic        etx, acc, popm, all_idle;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, g, cyc, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Model compare, serial receive and model advance for the coming edge
    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < ND; g++) begin
            if (!rst) begin
                q_m[g].delete();
                sbq[g].delete();
                rem[g]    = 0;
                rx_act[g] = 1'b0;
            end
            fl  = nbits(g) * CPB;
            etx = (rem[g] > 0) ? fb[g][(fl - rem[g]) / CPB] : 1'b1;
            chk("tx", g, 32'(txl[g]), 32'(etx));
            chk("tx_busy", g, 32'(bsy[g]), 32'(rem[g] > 0));
            chk("fifo_level", g, 32'(lvl[g]), 32'(q_m[g].size()));
            chk("tx_ready", g, 32'(rdy[g]), 32'(q_m[g].size() < cfg_dp(g)));

            if (rst) begin
                if (rx_act[g]) begin
                    if (rx_cnt[g] % CPB == CPB/2) begin
                        rx_b[g][rx_cnt[g] / CPB] = txl[g];
                        if (rx_cnt[g] / CPB == nbits(g) - 1) begin
                            rx_act[g] = 1'b0;
                            if (sbq[g].size() == 0) begin
                                chk("rx_unexpected_frame", g, 32'd1, 32'd0);
                            end else begin
                                ew = sbq[g].pop_front();
                                ef = frame_of(g, ew);
                                rw = '0;
                                for (int i = 0; i < cfg_dw(g); i++) rw[i] = rx_b[g][1+i];
                                chk("rx_start", g, 32'(rx_b[g][0]), 32'd0);
                                chk("rx_word", g, rw, 32'(ew));
                                if (cfg_par(g) != 0)
                                    chk("rx_parity", g, 32'(rx_b[g][1+cfg_dw(g)]), 32'(ef[1+cfg_dw(g)]));
                                for (int s = 0; s < cfg_sb(g); s++)
                                    chk("rx_stop", g, 32'(rx_b[g][nbits(g)-1-s]), 32'd1);
                            end
                        end
                    end
                    rx_cnt[g]++;
                end else if (txl[g] == 1'b0) begin
                    rx_act[g] = 1'b1;
                    rx_cnt[g] = 1;
                end

                acc  = vld[g] && (q_m[g].size() < cfg_dp(g));
                popm = (q_m[g].size() > 0) && (rem[g] <= 1);
                if (rem[g] > 0) rem[g]--;
                if (popm) begin
                    w      = q_m[g].pop_front();
                    fb[g]  = frame_of(g, w);
                    rem[g] = fl;
                end
                if (acc) begin
                    w = int'(dat[g]) & ((1 << cfg_dw(g)) - 1);
                    q_m[g].push_back(w);
                    sbq[g].push_back(w);
                end
            end
        end

        if (stim_done) begin
            all_idle = 1'b1;
            for (int g = 0; g < ND; g++)
                if (rem[g] != 0 || q_m[g].size() != 0 || sbq[g].size() != 0 || rx_act[g])
                    all_idle = 1'b0;
            if (all_idle) begin
                chk("stimulus_budget", 0, 32'(stim_err), 32'd0);
                finish_run();
            end
        end
        if (cyc > 40000) begin
            chk("timeout", 0, 32'd1, 32'd0);
            finish_run();
        end
        if (fails >= 100) finish_run();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [8:0] d0, input logic [8:0] d1, input logic [8:0] d2);
        dat[0] = d0; dat[1] = d1; dat[2] = d2;
        for (int g = 0; g < ND; g++) vld[g] = 1'b1;
        step();
        for (int g = 0; g < ND; g++) vld[g] = 1'b0;
    endtask

    // Offer n consecutive words per DUT, holding each until it is taken
    task automatic stream(input int n, input int base, input int budget);
        int k [ND];
        int t;
        logic busy;
        for (int g = 0; g < ND; g++) k[g] = 0;
        t    = 0;
        busy = 1'b1;
        while (busy && t < budget) begin
            for (int g = 0; g < ND; g++) begin
                vld[g] = (k[g] < n);
                dat[g] = 9'(base + k[g]);
            end
            @(negedge clk);
            for (int g = 0; g < ND; g++) if (vld[g] && rdy[g]) k[g]++;
            step();
            t++;
            busy = 1'b0;
            for (int g = 0; g < ND; g++) if (k[g] < n) busy = 1'b1;
        end
        for (int g = 0; g < ND; g++) vld[g] = 1'b0;
        if (busy) stim_err = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        logic quiet;
        t     = 0;
        quiet = 1'b0;
        while (!quiet && t < budget) begin
            step();
            t++;
            quiet = 1'b1;
            for (int g = 0; g < ND; g++) if (bsy[g] || lvl[g] != 0) quiet = 1'b0;
        end
        if (!quiet) stim_err = 1'b1;
    endtask

    initial begin
        int pr [6];
        pr = '{90, 20, 70, 5, 100, 50};
        rst       = 1'b0;
        stim_done = 1'b0;
        stim_err  = 1'b0;
        for (int g = 0; g < ND; g++) begin
            vld[g] = 1'b0;
            dat[g] = '0;
        end
        repeat (3) step();
        rst = 1'b1;
        step();

        // single words from idle
        send1(9'h055, 9'h1A5, 9'h007);
        repeat (260) step();
        send1(9'h007, 9'h007, 9'h055);
        repeat (260) step();

        // back-to-back burst that overfills the FIFO
        stream(6, 1, 2000);
        wait_idle(2000);

        // random traffic at varying load
        for (int c = 0; c < 6; c++) begin
            repeat (500) begin
                for (int g = 0; g < ND; g++) begin
                    vld[g] = ($urandom_range(99) < pr[c]);
                    dat[g] = 9'($urandom);
                end
                step();
            end
        end
        for (int g = 0; g < ND; g++) vld[g] = 1'b0;
        wait_idle(3000);

        // reset in the middle of data bit 3 with two words queued
        dat[0] = 9'h0AA; dat[1] = 9'h0AA; dat[2] = 9'h0AA;
        for (int g = 0; g < ND; g++) vld[g] = 1'b1;
        step();
        for (int g = 0; g < ND; g++) dat[g] = 9'($urandom);
        step();
        for (int g = 0; g < ND; g++) dat[g] = 9'($urandom);
        step();
        for (int g = 0; g < ND; g++) vld[g] = 1'b0;
        repeat (68) step();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        repeat (300) step();

        // pointer wrap-around with a near-full FIFO
        stream(12, 'h10, 5000);
        wait_idle(3000);
        stim_done = 1'b1;
    end

endmodule

// File: doc/uart_tx_gen.md
# uart_tx_gen

Parametrised UART transmitter, the successor to `uart_tx`. It adds these capabilities:
- configurable data width, parity and stop bits;
- an internal transmit FIFO, so the producer can queue several words;
- gapless back-to-back frames.

It sits between a byte/word producer and the serial line, and is frame-compatible with `uart_rx` when configured 8N1.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit period (≥2).
- `DATA_W`, 8, data bits per frame (5–9).
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1, stop bits per frame (1 or 2).
- `FIFO_DEPTH`, 4, transmit FIFO entries (power of 2, ≥2).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tx_data`  in  DATA_W  word to transmit.
- `tx_valid`  in  1  producer has a word on `tx_data`.
- `tx_ready`  out  1  FIFO can accept a word (not full).
- `tx`  out  1  serial line, idle high, registered.
- `tx_busy`  out  1  a frame is on the line.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  number of words queued, excluding the word in flight.

## Operation
- **Accept:** a word is written on a rising edge where `tx_valid && tx_ready`.
- **Full FIFO:** `tx_ready` = !full. A pop in the same cycle does not make room for a write in that cycle.
- **FSM states:**
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: DATA_W bits, LSB first.
  - PARITY: present only if PARITY≠0.
  - STOP: `tx`=1 for STOP_BITS bit periods.
- **Pop:** the word is popped into a shift register on entry to START.
- **Parity bit:**
  - even mode: XOR of the data bits;
  - odd mode: its inverse.
- **Bit period:** every bit holds for exactly CLKS_PER_BIT cycles. A bit counter counts 0..CLKS_PER_BIT-1 and wraps.
- **End of last stop bit:**
  - FIFO non-empty → go directly to START on the next cycle (no idle cycle);
  - otherwise → IDLE.
- `tx_busy` = 1 in every state except IDLE.
- **Reset (mid-frame or otherwise):**
  - the frame is aborted and the FIFO is flushed;
  - `tx`=1, `tx_ready`=1, `tx_busy`=0, `fifo_level`=0, FSM=IDLE;
  - all take effect immediately and asynchronously.
- **`tx_data` changes:** ignored once a word is accepted; the FIFO holds its own copy.

## Timing
- Frame length = (1 + DATA_W + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- **Latency from IDLE:**
  - word accepted at edge k → FIFO non-empty after edge k;
  - FSM pops at edge k+1, and `tx` falls after edge k+1;
  - `tx_busy` rises after edge k+1, together with `tx`.
- `fifo_level` updates on the edge of the write/pop.
  - Simultaneous write and pop leaves it unchanged.
- **Read/write pointers:** log2(FIFO_DEPTH) bits each, wrapping modulo FIFO_DEPTH. Full/empty is derived from `fifo_level`.
- All outputs are registered. There is no combinational path from `tx_valid` to `tx_ready`.

## Structure
- Shared package `uart_pkg` holds:
  - parity constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - FSM state encodings S_IDLE, S_START, S_DATA, S_PARITY, S_STOP;
  - the default CLKS_PER_BIT.
- One sub-module: `uart_fifo`, a synchronous FIFO parametrised by width/depth, with wr_en/rd_en, full, empty and level outputs.
- The serializer FSM, bit counter and shift register live in `uart_tx_gen`.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- **8N1 single word:** reset, write 0x55 at edge k.
  - `tx`=0 over cycles k+1..k+16, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then 1.
  - `tx_busy` is high for exactly 160 cycles.
- **Parity:** 8E1 with 0x07 → parity bit 1, frame 176 cycles. 8O1 with 0x07 → parity bit 0.
- **Back-to-back, FIFO_DEPTH=4:** write 0x01..0x05 on 5 consecutive edges.
  - 0x01 is popped after its write, so `tx_ready` goes low after the 5th accept with `fifo_level`=4.
  - A 6th `tx_valid` is not accepted until the first pop after that.
  - The five frames are gapless, with `tx_busy` high for 800 contiguous cycles.
- **DATA_W=9, STOP_BITS=2:** word 0x1A5 → data bits LSB-first 1,0,1,0,0,1,0,1,1, then two stop bits; frame 192 cycles.
- **Reset mid-frame:** assert `rst`=0 during the DATA bit 3 of 0xAA with 2 words queued.
  - `tx`=1, `fifo_level`=0, `tx_ready`=1 immediately.
  - After release, no frame is sent until a new write.
- **Wrap-around:** stream 12 words 0x10..0x1B through FIFO_DEPTH=4, keeping it near full. All 12 are received in order by `uart_rx` (configured 8N1, same CLKS_PER_BIT), with no loss or duplication.
